// File: rtl/jpeg_rle_pkg.sv
// Shared constants, scheduler state encoding and the 11-bit saturation helper
// for the JPEG run-length block scheduler.
package jpeg_rle_pkg;

  localparam int DW      = 11;
  localparam int BLK_LEN = 64;
  localparam int CID_W   = 3;
  localparam int ADDR_W  = 6;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    GAP
  } sched_state_t;

  // Clamp a 12-bit signed difference into the 11-bit sample range.
  function automatic logic signed [DW-1:0] sat11(input logic signed [DW:0] v);
    if (v > 12'sd1023) begin
      return 11'sh3FF;
    end else if (v < -12'sd1024) begin
      return 11'sh400;
    end else begin
      return v[DW-1:0];
    end
  endfunction

endpackage

// File: rtl/jpeg_rle_tagfifo.sv
// Component-tag FIFO: push/pop in the cycle they are asserted, head is the oldest tag.
// Push while full and pop while empty are ignored; the caller decides whether that is an error.
module jpeg_rle_tagfifo #(
  parameter int DEPTH = 4,
  parameter int W     = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] push_dat_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= push_dat_i;
        wr_q        <= nxt(wr_q);
      end
      if (do_pop) rd_q <= nxt(rd_q);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/jpeg_rle_sched.sv
// Round-robin block scheduler feeding the RLE chain; samples reach rle_din 2 ena-cycles after rd_addr.
// Grants stall while the tag FIFO is full; optional DC prediction under JPEG_RLE_DCPRED_EN.
module jpeg_rle_sched
  import jpeg_rle_pkg::*;
#(
  parameter int NREQ      = 3,
  parameter int TAG_DEPTH = 4,
  parameter int BLK_GAP   = 0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               ena_i,
  input  logic [NREQ-1:0]    req_i,
  output logic [NREQ-1:0]    gnt_o,
  output logic               rd_en_o,
  output logic [ADDR_W-1:0]  rd_addr_o,
  input  logic [NREQ*DW-1:0] rd_data_i,
  input  logic               pred_clr_i,
  output logic               rle_ena_o,
  output logic               rle_dstrb_o,
  output logic [DW-1:0]      rle_din_o,
  input  logic               rle_douten_i,
  input  logic               rle_bstart_i,
  output logic [CID_W-1:0]   blk_comp_o,
  output logic               busy_o,
  output logic               tag_err_o
);

  localparam int NSRC = 2**CID_W;

  sched_state_t        state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic [CID_W-1:0]    rr_q, rr_d;
  logic [15:0]         gap_q, gap_d;
  logic                push, pop, fifo_full, fifo_empty;
  logic [CID_W-1:0]    fifo_head;
  logic                win_vld;
  logic [CID_W-1:0]    win_idx, cand;
  logic [NSRC-1:0]     req_pad, win_oh;

  logic                v1_q, first1_q;
  logic [CID_W-1:0]    sel1_q;
  logic [DW-1:0]       din_q, din_d;
  logic                dstrb_q, tag_err_q;
  logic [DW-1:0]       src [NSRC];
  logic [DW-1:0]       src_sel;

  assign req_pad = NSRC'(req_i);

  // Scan upward from the last granted index so the previous winner is checked last.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = CID_W'((int'(rr_q) + k) % NREQ);
      if (req_pad[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign win_oh = NSRC'(1) << win_idx;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    gap_d   = gap_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_vld && !fifo_full) begin
          state_d = READ;
          addr_d  = '0;
          gnt_d   = win_oh[NREQ-1:0];
          rr_d    = win_idx;
          push    = ena_i;
        end
      end
      READ: begin
        if (addr_q == ADDR_W'(BLK_LEN-1)) begin
          gnt_d   = '0;
          addr_d  = '0;
          gap_d   = '0;
          state_d = (BLK_GAP > 0) ? GAP : IDLE;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      GAP: begin
        if (gap_q == 16'(BLK_GAP-1)) state_d = IDLE;
        else                         gap_d   = gap_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      gnt_q   <= '0;
      rr_q    <= CID_W'(NREQ-1);
      gap_q   <= '0;
    end else if (ena_i) begin
      state_q <= state_d;
      addr_q  <= addr_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      gap_q   <= gap_d;
    end
  end

  for (genvar g = 0; g < NSRC; g++) begin : g_src
    if (g < NREQ) begin : g_on
      assign src[g] = rd_data_i[g*DW +: DW];
    end else begin : g_off
      assign src[g] = '0;
    end
  end

  assign src_sel = src[sel1_q];

`ifdef JPEG_RLE_DCPRED_EN
  logic signed [DW-1:0] pred_q [NSRC];
  logic signed [DW-1:0] pred_eff;
  logic signed [DW:0]   dc_diff;

  // A coincident clear means sample 0 is differenced against zero.
  assign pred_eff = pred_clr_i ? '0 : pred_q[sel1_q];
  assign dc_diff  = $signed({src_sel[DW-1], src_sel}) - $signed({pred_eff[DW-1], pred_eff});
  assign din_d    = first1_q ? sat11(dc_diff) : src_sel;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < NSRC; i++) pred_q[i] <= '0;
    end else if (ena_i) begin
      if (pred_clr_i) begin
        for (int i = 0; i < NSRC; i++) pred_q[i] <= '0;
      end
      if (v1_q && first1_q) pred_q[sel1_q] <= src_sel;
    end
  end
`else
  logic unused_pred_clr;
  assign unused_pred_clr = pred_clr_i;
  assign din_d           = src_sel;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      v1_q      <= 1'b0;
      first1_q  <= 1'b0;
      sel1_q    <= '0;
      din_q     <= '0;
      dstrb_q   <= 1'b0;
      tag_err_q <= 1'b0;
    end else if (ena_i) begin
      v1_q     <= (state_q == READ);
      first1_q <= (state_q == READ) && (addr_q == '0);
      sel1_q   <= rr_q;
      dstrb_q  <= v1_q & first1_q;
      if (v1_q) din_q <= din_d;
      if (rle_douten_i && rle_bstart_i && fifo_empty) tag_err_q <= 1'b1;
    end
  end

  assign pop = ena_i & rle_douten_i & rle_bstart_i;

  jpeg_rle_tagfifo #(
    .DEPTH (TAG_DEPTH),
    .W     (CID_W)
  ) u_tagfifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (push),
    .push_dat_i (win_idx),
    .pop_i      (pop),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .head_o     (fifo_head)
  );

  assign gnt_o       = gnt_q;
  assign rd_en_o     = (state_q == READ);
  assign rd_addr_o   = addr_q;
  assign rle_ena_o   = ena_i;
  assign rle_dstrb_o = dstrb_q;
  assign rle_din_o   = din_q;
  assign blk_comp_o  = fifo_head;
  assign busy_o      = (state_q != IDLE) || !fifo_empty;
  assign tag_err_o   = tag_err_q;

endmodule
